// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipe_stage_reg block.
//   pipe_state_t   occupancy state of a stage register (EMPTY/FULL/SKID)
//   PIPE_CTRL_NOP  all-zero control field carried by flushed/reset entries
//   DEF_*          default widths used as parameter defaults
package pipe_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_CTRL_W = 9;
  localparam int DEF_CNT_W  = 16;

  localparam logic [DEF_CTRL_W-1:0] PIPE_CTRL_NOP = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: W-bit up counter that sticks at all-ones.
//   i_clk   rising-edge clock
//   i_rst   asynchronous active-high reset (clears count)
//   i_en    count enable
//   o_count current count
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_cnt;
  logic         w_sat;

  assign w_sat   = &r_cnt;
  assign o_count = r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)              r_cnt <= '0;
    else if (i_en && !w_sat) r_cnt <= r_cnt + W'(1);
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline stage register carrying an
// opaque control field and a data payload between datapath stages.
//
// Build option: define PIPE_SKID_EN to add a skid entry so inReady depends
// only on a flop (and hit); without it inReady passes outReady through.
//
// Ports:
//   Clk, Rst            clock, asynchronous active-high reset
//   hit                 global run enable (0 freezes everything but stallCount)
//   flush               synchronous kill of all held entries (beats everything)
//   inValid/inReady     upstream handshake, inCtrl/inData upstream entry
//   outValid/outReady   downstream handshake, outCtrl/outData registered entry
//   stallCount          saturating count of cycles with a stalled output
module pipe_stage_reg import pipe_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              hit,
  input  logic              flush,
  input  logic              inValid,
  output logic              inReady,
  input  logic [CTRL_W-1:0] inCtrl,
  input  logic [DATA_W-1:0] inData,
  output logic              outValid,
  input  logic              outReady,
  output logic [CTRL_W-1:0] outCtrl,
  output logic [DATA_W-1:0] outData,
  output logic [CNT_W-1:0]  stallCount
);

  localparam logic [CTRL_W-1:0] NOP = CTRL_W'(PIPE_CTRL_NOP);

  pipe_state_t r_state, w_state_nxt;

  // Valid bits are kept as their own flops (not decoded from r_state) so
  // outValid is a pure register output.
  logic              r_main_vld;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;

  logic w_acc, w_rel;
  logic w_ld_main_in, w_ld_main_skid, w_ld_skid;

`ifdef PIPE_SKID_EN
  logic              r_skid_vld;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  // Ready is a flop plus hit only; !Rst keeps it low during reset.
  assign inReady = !r_skid_vld & hit & !Rst;
`else
  // Combinational pass-through: room exists if empty or the held entry
  // leaves this cycle.
  assign inReady = hit & (!r_main_vld | outReady) & !Rst;
`endif

  assign w_acc = inValid & inReady & hit;
  assign w_rel = r_main_vld & outReady & hit;

  // Next-state / load selection. With hit=0 neither acc nor rel can fire,
  // so the stage naturally holds.
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_acc) begin
          w_state_nxt  = FULL;
          w_ld_main_in = 1'b1;
        end
        FULL: begin
          if (w_acc && w_rel) begin
            w_ld_main_in = 1'b1;
          end else if (w_rel) begin
            w_state_nxt = EMPTY;
          end else if (w_acc) begin
            // Only reachable with a skid entry; otherwise inReady is 0 here.
            w_state_nxt = SKID;
            w_ld_skid   = 1'b1;
          end
        end
`ifdef PIPE_SKID_EN
        SKID: if (w_rel) begin
          // Older skid entry drains into main before anything newer.
          w_state_nxt    = FULL;
          w_ld_main_skid = 1'b1;
        end
`endif
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state    <= EMPTY;
      r_main_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_main_vld <= (w_state_nxt != EMPTY);
    end
  end

  // Flush zeroes control only; data is left as-is since a NOP control
  // already makes the payload meaningless downstream.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_main_ctrl <= NOP;
      r_main_data <= '0;
    end else if (flush) begin
      r_main_ctrl <= NOP;
    end else if (w_ld_main_in) begin
      r_main_ctrl <= inCtrl;
      r_main_data <= inData;
`ifdef PIPE_SKID_EN
    end else if (w_ld_main_skid) begin
      r_main_ctrl <= r_skid_ctrl;
      r_main_data <= r_skid_data;
`endif
    end
  end

`ifdef PIPE_SKID_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_skid_vld  <= 1'b0;
      r_skid_ctrl <= NOP;
      r_skid_data <= '0;
    end else begin
      r_skid_vld <= (w_state_nxt == SKID);
      if (flush) begin
        r_skid_ctrl <= NOP;
      end else if (w_ld_skid) begin
        r_skid_ctrl <= inCtrl;
        r_skid_data <= inData;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = w_ld_main_skid | w_ld_skid;
`endif

  assign outValid = r_main_vld;
  assign outCtrl  = r_main_ctrl;
  assign outData  = r_main_data;

  // Stalled output: an entry is present but cannot leave this cycle.
  logic w_stall;
  assign w_stall = r_main_vld & (!outReady | !hit);

  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_en    (w_stall),
    .o_count (stallCount)
  );

endmodule
